smvm_issue_ctrl: RTL and testbench
==================================

SMVM_ISSUE_CTRL -- requirements
Module: smvm_issue_ctrl

Interface
REQ-001 Parameter K, default 4: lanes per batch, equal to ALU L1 width.
REQ-002 Parameter CREDITS, default 2: maximum batches in flight between issue and output-buffer drain.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that opens one matrix.
REQ-006 nnz_valid  input  1  nonzero entry present on the nnz_* inputs.
REQ-007 nnz_ready  output  1  controller accepts the entry this cycle.
REQ-008 nnz_val  input  8  signed matrix value.
REQ-009 nnz_col  input  7  column index into the 128-entry vector store.
REQ-010 nnz_ipv  input  1  row-boundary flag (IPV bit) of the entry.
REQ-011 nnz_last  input  1  entry is the final nonzero of the matrix.
REQ-012 issue_valid  output  1  single-cycle batch issue strobe to the ALU/map-table pipeline.
REQ-013 issue_val  output  8*K  lane values, lane 0 in bits [7:0].
REQ-014 issue_col  output  7*K  lane column indices, lane 0 in bits [6:0].
REQ-015 issue_ipv  output  K  lane IPV bits.
REQ-016 issue_mask  output  K  lane-occupied flags.
REQ-017 credit_ret  input  1  pulse: downstream has drained one batch.
REQ-018 busy  output  1  high from the cycle after an accepted start until done.
REQ-019 done  output  1  single-cycle pulse when the matrix is fully drained.
REQ-020 perf_issues  output  16  batch-issue counter (see Configuration).
REQ-021 perf_stalls  output  16  credit-stall cycle counter (see Configuration).

Function
REQ-022 The controller SHALL implement the states IDLE, FILL, ISSUE and DRAIN.
REQ-023 IDLE: nnz_ready=0; start moves to FILL with lane_cnt=0; start is ignored in every other state.
REQ-024 FILL: nnz_ready=1; on nnz_valid&nnz_ready, lane[lane_cnt] captures val/col/ipv, sets its mask bit and increments lane_cnt.
REQ-025 FILL→ISSUE on the cycle that accepts the K-th entry or any entry with nnz_last=1.
REQ-026 ISSUE: nnz_ready=0; when credits>0, issue_valid=1 for exactly one cycle and credits decrements; while credits==0, the state holds ISSUE and the batch holds stable.
REQ-027 Unoccupied lanes SHALL drive val=0, col=0, ipv=0 and mask=0.
REQ-028 issue_* buses are valid only while issue_valid=1 and otherwise hold the last batch.
REQ-029 After an issue: go to DRAIN if the batch held nnz_last; otherwise go to FILL with lane_cnt=0 and all masks cleared.
REQ-030 DRAIN: when credits==CREDITS, pulse done for one cycle and return to IDLE.
REQ-031 credit_ret increments credits and saturates at CREDITS.
REQ-032 credit_ret in the same cycle as an issue leaves credits unchanged.
REQ-033 Minimum latency: the issue strobe follows the completing accept by 1 cycle when credits>0.
REQ-034 nnz_last on lane K-1 yields a full batch, then DRAIN; no empty batch is ever issued.

Reset
REQ-035 While rst_n=0: state=IDLE, lane_cnt=0, credits=CREDITS, lane registers and masks=0.
REQ-036 While rst_n=0, all outputs are 0: nnz_ready, issue_*, busy, done, perf_*.
REQ-037 Reset mid-matrix discards the partial batch and all in-flight credit accounting.

Configuration
REQ-038 With SMVM_ISSUE_PERF_EN defined, perf_issues counts issue strobes and perf_stalls counts cycles in ISSUE with credits==0.
REQ-039 With SMVM_ISSUE_PERF_EN defined, both counters saturate at 16'hFFFF and clear on an accepted start.
REQ-040 Without SMVM_ISSUE_PERF_EN, perf_issues and perf_stalls are tied to 0 and no counter flops exist.

Structure
REQ-041 Shared package smvm_pkg SHALL hold K, CREDITS, VAL_W=8, COL_W=7 and the state enumeration.
REQ-042 Credit tracking SHALL be a sub-module smvm_credit_cnt with inputs take and give, output avail and parameter CREDITS.

Verification
REQ-043 8 entries (val 1..8, col 0..7, ipv on entries 4 and 8, last on entry 8), credit_ret returned 5 cycles after each issue → 2 issues, masks 4'b1111 both, then done.
REQ-044 6 entries, last on entry 6 → second issue has mask 4'b0011, lanes 2-3 zero, then DRAIN and done after 2 credits return.
REQ-045 12 entries, no credit_ret until cycle 30 → third batch stalls in ISSUE with buses stable and nnz_ready=0; perf_stalls equals the stall cycles when SMVM_ISSUE_PERF_EN is defined.
REQ-046 credit_ret coincident with an issue at credits=1 → credits remains 1 and the next batch issues without stalling.
REQ-047 rst_n asserted after 3 accepted entries → all outputs 0 immediately; a new start with 4 entries issues cleanly with credits=2.
REQ-048 start pulsed while busy, and nnz_valid asserted in IDLE → both ignored, with no accept and no issue.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared types and default sizing for the SpMV issue controller.
// Consumers: smvm_issue_ctrl, smvm_credit_cnt.
package smvm_pkg;

    localparam int K       = 4;
    localparam int CREDITS = 2;
    localparam int VAL_W   = 8;
    localparam int COL_W   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/smvm_credit_cnt.sv
// Saturating credit counter between batch issue and output-buffer drain.
// take consumes one credit, give returns one; both together cancel out.
module smvm_credit_cnt #(
    parameter int CREDITS = 2,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          take,
    input  logic          give,
    output logic [CW-1:0] avail
);

    logic [CW-1:0] avail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avail_q <= CW'(CREDITS);
        end else if (take && !give) begin
            if (avail_q != '0) avail_q <= avail_q - CW'(1);
        end else if (give && !take) begin
            if (avail_q != CW'(CREDITS)) avail_q <= avail_q + CW'(1);
        end
    end

    assign avail = avail_q;

endmodule

// File: rtl/smvm_issue_ctrl.sv
// Packs nonzero entries into K-lane batches and issues them under credit flow control.
// Optional performance counters are built when SMVM_ISSUE_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, no entries accepted
// FILL  | accepting entries into lanes until K lanes or nnz_last
// ISSUE | batch complete, strobing issue_valid once a credit is available
// DRAIN | last batch issued, waiting for all credits to return
module smvm_issue_ctrl #(
    parameter int K       = smvm_pkg::K,
    parameter int CREDITS = smvm_pkg::CREDITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          nnz_valid,
    output logic                          nnz_ready,
    input  logic [smvm_pkg::VAL_W-1:0]    nnz_val,
    input  logic [smvm_pkg::COL_W-1:0]    nnz_col,
    input  logic                          nnz_ipv,
    input  logic                          nnz_last,
    output logic                          issue_valid,
    output logic [K*smvm_pkg::VAL_W-1:0]  issue_val,
    output logic [K*smvm_pkg::COL_W-1:0]  issue_col,
    output logic [K-1:0]                  issue_ipv,
    output logic [K-1:0]                  issue_mask,
    input  logic                          credit_ret,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   perf_issues,
    output logic [15:0]                   perf_stalls
);

    import smvm_pkg::*;

    localparam int LCNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int CRED_W = $clog2(CREDITS + 1);

    state_e                       state_q, state_d;
    logic [LCNT_W-1:0]            lane_cnt_q, lane_cnt_d;
    logic [K-1:0][VAL_W-1:0]      val_q, val_d;
    logic [K-1:0][COL_W-1:0]      col_q, col_d;
    logic [K-1:0]                 ipv_q, ipv_d;
    logic [K-1:0]                 mask_q, mask_d;
    logic                         last_q, last_d;

    logic [K-1:0][VAL_W-1:0]      hold_val_q;
    logic [K-1:0][COL_W-1:0]      hold_col_q;
    logic [K-1:0]                 hold_ipv_q;
    logic [K-1:0]                 hold_mask_q;

    logic [CRED_W-1:0]            credits;
    logic                         issue_fire;

    smvm_credit_cnt #(
        .CREDITS (CREDITS),
        .CW      (CRED_W)
    ) u_credit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .take  (issue_fire),
        .give  (credit_ret),
        .avail (credits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            val_q      <= '0;
            col_q      <= '0;
            ipv_q      <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            val_q      <= val_d;
            col_q      <= col_d;
            ipv_q      <= ipv_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        val_d      = val_q;
        col_d      = col_q;
        ipv_d      = ipv_q;
        mask_d     = mask_q;
        last_d     = last_q;
        nnz_ready  = 1'b0;
        issue_fire = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    lane_cnt_d = '0;
                    val_d      = '0;
                    col_d      = '0;
                    ipv_d      = '0;
                    mask_d     = '0;
                    last_d     = 1'b0;
                end
            end
            FILL: begin
                nnz_ready = 1'b1;
                if (nnz_valid) begin
                    val_d[lane_cnt_q]  = nnz_val;
                    col_d[lane_cnt_q]  = nnz_col;
                    ipv_d[lane_cnt_q]  = nnz_ipv;
                    mask_d[lane_cnt_q] = 1'b1;
                    lane_cnt_d         = lane_cnt_q + LCNT_W'(1);
                    last_d             = nnz_last;
                    if (nnz_last || (lane_cnt_q == LCNT_W'(K - 1))) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credits != '0) begin
                    issue_fire = 1'b1;
                    if (last_q) begin
                        state_d = DRAIN;
                    end else begin
                        // unused lanes of the next batch must read back as zero
                        state_d    = FILL;
                        lane_cnt_d = '0;
                        val_d      = '0;
                        col_d      = '0;
                        ipv_d      = '0;
                        mask_d     = '0;
                    end
                end
            end
            DRAIN: begin
                if (credits == CRED_W'(CREDITS)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot of the last issued batch so the buses stay put between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_val_q  <= '0;
            hold_col_q  <= '0;
            hold_ipv_q  <= '0;
            hold_mask_q <= '0;
        end else if (issue_fire) begin
            hold_val_q  <= val_q;
            hold_col_q  <= col_q;
            hold_ipv_q  <= ipv_q;
            hold_mask_q <= mask_q;
        end
    end

    assign issue_valid = issue_fire;
    assign issue_val   = (state_q == ISSUE) ? val_q  : hold_val_q;
    assign issue_col   = (state_q == ISSUE) ? col_q  : hold_col_q;
    assign issue_ipv   = (state_q == ISSUE) ? ipv_q  : hold_ipv_q;
    assign issue_mask  = (state_q == ISSUE) ? mask_q : hold_mask_q;
    assign busy        = (state_q != IDLE);

`ifdef SMVM_ISSUE_PERF_EN
    logic [15:0] perf_issues_q;
    logic [15:0] perf_stalls_q;
    logic        start_acc;

    assign start_acc = (state_q == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issues_q <= '0;
            perf_stalls_q <= '0;
        end else if (start_acc) begin
            perf_issues_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (issue_fire && (perf_issues_q != 16'hFFFF)) begin
                perf_issues_q <= perf_issues_q + 16'd1;
            end
            if ((state_q == ISSUE) && (credits == '0) && (perf_stalls_q != 16'hFFFF)) begin
                perf_stalls_q <= perf_stalls_q + 16'd1;
            end
        end
    end

    assign perf_issues = perf_issues_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_issues = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_smvm_issue_ctrl.sv
// Scoreboard bench for smvm_issue_ctrl (K=4, CREDITS=2): expected batches are
// queued as entries are accepted and compared on every issue strobe.
module tb_smvm_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        nnz_valid;
    logic        nnz_ready;
    logic [7:0]  nnz_val;
    logic [6:0]  nnz_col;
    logic        nnz_ipv;
    logic        nnz_last;
    logic        issue_valid;
    logic [31:0] issue_val;
    logic [27:0] issue_col;
    logic [3:0]  issue_ipv;
    logic [3:0]  issue_mask;
    logic        credit_ret;
    logic        busy;
    logic        done;
    logic [15:0] perf_issues;
    logic [15:0] perf_stalls;

    smvm_issue_ctrl #(.K(4), .CREDITS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .nnz_valid   (nnz_valid),
        .nnz_ready   (nnz_ready),
        .nnz_val     (nnz_val),
        .nnz_col     (nnz_col),
        .nnz_ipv     (nnz_ipv),
        .nnz_last    (nnz_last),
        .issue_valid (issue_valid),
        .issue_val   (issue_val),
        .issue_col   (issue_col),
        .issue_ipv   (issue_ipv),
        .issue_mask  (issue_mask),
        .credit_ret  (credit_ret),
        .busy        (busy),
        .done        (done),
        .perf_issues (perf_issues),
        .perf_stalls (perf_stalls)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] val;
        logic [27:0] col;
        logic [3:0]  ipv;
        logic [3:0]  mask;
    } batch_t;

    batch_t sb_q[$];
    batch_t m_b;
    batch_t mon_e;
    int     m_lane;
    int     checks;
    int     errors;
    int     cyc;
    int     ret_q[$];
    int     auto_d;
    int     coinc_n;
    int     issue_cnt;
    int     done_cnt;
    int     iss_cyc[$];
    int     acc_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each issue and schedules delayed credit returns
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (issue_valid) begin
                issue_cnt++;
                iss_cyc.push_back(cyc);
                if (auto_d > 0) ret_q.push_back(cyc + auto_d);
                if (sb_q.size() == 0) begin
                    chk("unexpected_issue", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("issue_val",  {32'd0, issue_val},  {32'd0, mon_e.val});
                    chk("issue_col",  {36'd0, issue_col},  {36'd0, mon_e.col});
                    chk("issue_ipv",  {60'd0, issue_ipv},  {60'd0, mon_e.ipv});
                    chk("issue_mask", {60'd0, issue_mask}, {60'd0, mon_e.mask});
                end
            end
        end
    end

    // Cycle counter and credit_ret driver
    initial begin
        cyc = 0;
        credit_ret = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            credit_ret = 1'b0;
            if (coinc_n > 0 && issue_valid && rst_n) begin
                credit_ret = 1'b1;
                coinc_n--;
            end else if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                void'(ret_q.pop_front());
                credit_ret = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input logic [6:0] c, input logic ipv, input logic last);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        nnz_valid = 1'b1;
        nnz_val   = v;
        nnz_col   = c;
        nnz_ipv   = ipv;
        nnz_last  = last;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (nnz_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        nnz_valid = 1'b0;
        nnz_last  = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            m_b.val[m_lane*8 +: 8] = v;
            m_b.col[m_lane*7 +: 7] = c;
            m_b.ipv[m_lane]        = ipv;
            m_b.mask[m_lane]       = 1'b1;
            m_lane++;
            if (m_lane == 4 || last) begin
                sb_q.push_back(m_b);
                m_b    = '0;
                m_lane = 0;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(done_cnt - d0), 64'd1);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("done_single", {63'd0, done}, 64'd0);
    endtask

    task automatic wait_issues(input int target, input int budget);
        int n;
        n = 0;
        while (issue_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("issue_wait", 64'(issue_cnt), 64'(target));
    endtask

    int i0;
    int s_cyc;
    int r_cyc;
    int a12;
    int nq;

    initial begin
        rst_n = 1'b0; start = 1'b0; nnz_valid = 1'b0; nnz_val = '0;
        nnz_col = '0; nnz_ipv = 1'b0; nnz_last = 1'b0;
        m_b = '0; m_lane = 0; auto_d = 0; coinc_n = 0;
        checks = 0; errors = 0; issue_cnt = 0; done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nnz_ready",   {63'd0, nnz_ready},   64'd0);
        chk("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
        chk("rst_issue_val",   {32'd0, issue_val},   64'd0);
        chk("rst_issue_col",   {36'd0, issue_col},   64'd0);
        chk("rst_issue_ipv",   {60'd0, issue_ipv},   64'd0);
        chk("rst_issue_mask",  {60'd0, issue_mask},  64'd0);
        chk("rst_busy",        {63'd0, busy},        64'd0);
        chk("rst_done",        {63'd0, done},        64'd0);
        chk("rst_perf_issues", {48'd0, perf_issues}, 64'd0);
        chk("rst_perf_stalls", {48'd0, perf_stalls}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // 8 entries, two full batches, credits returned 5 cycles after each issue
        auto_d = 5;
        i0 = issue_cnt;
        do_start();
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 7'(i - 1), (i == 4 || i == 8), (i == 8));
            if (i == 4) chk("latency_b1", {63'd0, issue_valid}, 64'd1);
        end
        wait_done("t1_done", 100);
        chk("t1_issues", 64'(issue_cnt - i0), 64'd2);

        // 6 entries, partial second batch
        i0 = issue_cnt;
        do_start();
        for (int i = 1; i <= 6; i++) begin
            send(8'(8'h10 + i), 7'(20 + i), (i == 3), (i == 6));
        end
        wait_done("t2_done", 100);
        chk("t2_issues", 64'(issue_cnt - i0), 64'd2);

        // 12 entries, no credits back until 30 cycles after start: third batch stalls
        auto_d = 0;
        i0 = issue_cnt;
        s_cyc = cyc;
        r_cyc = s_cyc + 30;
        ret_q.push_back(r_cyc);
        ret_q.push_back(r_cyc + 5);
        ret_q.push_back(r_cyc + 7);
        do_start();
        for (int i = 1; i <= 12; i++) begin
            send(8'(8'h20 + i), 7'(40 + i), (i % 4 == 0), (i == 12));
        end
        a12 = acc_cyc;
        repeat (5) begin
            @(negedge clk);
            chk("stall_ready",  {63'd0, nnz_ready},   64'd0);
            chk("stall_valid",  {63'd0, issue_valid}, 64'd0);
            chk("stall_val",    {32'd0, issue_val},   {32'd0, 32'h2c2b2a29});
            chk("stall_mask",   {60'd0, issue_mask},  64'hf);
        end
        @(posedge clk);
        #1;
        wait_issues(i0 + 3, 60);
        nq = iss_cyc.size();
        chk("stall_release_cyc", 64'(iss_cyc[nq-1]), 64'(r_cyc + 1));
`ifdef SMVM_ISSUE_PERF_EN
        chk("perf_stalls", {48'd0, perf_stalls}, 64'(r_cyc - a12));
        chk("perf_issues", {48'd0, perf_issues}, 64'd3);
`else
        chk("perf_stalls_off", {48'd0, perf_stalls}, 64'd0);
        chk("perf_issues_off", {48'd0, perf_issues}, 64'd0);
`endif
        wait_done("t3_done", 100);

        // credit_ret coincident with issue at credits=1: no stall on the next batch
        i0 = issue_cnt;
        do_start();
        for (int i = 1; i <= 12; i++) begin
            send(8'(8'h40 + i), 7'(60 + i), (i == 2), (i == 12));
            if (i == 5) coinc_n = 2;
        end
        wait_issues(i0 + 3, 40);
        nq = iss_cyc.size();
        chk("coinc_gap_12", 64'(iss_cyc[nq-2] - iss_cyc[nq-3]), 64'd5);
        chk("coinc_gap_23", 64'(iss_cyc[nq-1] - iss_cyc[nq-2]), 64'd5);
        chk("coinc_used", 64'(coinc_n), 64'd0);
        ret_q.push_back(cyc + 2);
        wait_done("t4_done", 100);

        // reset in the middle of a matrix
        auto_d = 3;
        do_start();
        for (int i = 1; i <= 3; i++) send(8'(8'h60 + i), 7'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, nnz_ready},   64'd0);
        chk("mid_rst_busy",  {63'd0, busy},        64'd0);
        chk("mid_rst_valid", {63'd0, issue_valid}, 64'd0);
        chk("mid_rst_val",   {32'd0, issue_val},   64'd0);
        chk("mid_rst_mask",  {60'd0, issue_mask},  64'd0);
        m_b = '0;
        m_lane = 0;
        ret_q.delete();
        @(negedge clk) rst_n = 1'b1;
        idle(1);
        i0 = issue_cnt;
        do_start();
        for (int i = 1; i <= 4; i++) send(8'(8'h70 + i), 7'(100 + i), (i == 4), (i == 4));
        chk("t5_latency", {63'd0, issue_valid}, 64'd1);
        wait_done("t5_done", 100);
        chk("t5_issues", 64'(issue_cnt - i0), 64'd1);

        // nnz_valid in IDLE and start while busy are both ignored
        auto_d = 4;
        i0 = issue_cnt;
        nnz_valid = 1'b1;
        nnz_val = 8'h99;
        nnz_col = 7'd9;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ready", {63'd0, nnz_ready}, 64'd0);
            chk("idle_busy",  {63'd0, busy},      64'd0);
            @(posedge clk);
            #1;
        end
        nnz_valid = 1'b0;
        idle(2);
        chk("idle_no_issue", 64'(issue_cnt - i0), 64'd0);
        do_start();
        send(8'h81, 7'd11, 1'b0, 1'b0);
        send(8'h82, 7'd12, 1'b1, 1'b0);
        do_start();
        send(8'h83, 7'd13, 1'b0, 1'b0);
        send(8'h84, 7'd14, 1'b1, 1'b1);
        wait_done("t6_done", 100);
        chk("t6_issues", 64'(issue_cnt - i0), 64'd1);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
